// File: rtl/ms_c2_pkg.sv
// Shared constants for the chunk-serial sign-magnitude / two's complement converter.
package ms_c2_pkg;

  // Conversion direction, sampled when an operand is accepted
  localparam logic MODE_MS2C2 = 1'b0;
  localparam logic MODE_C22MS = 1'b1;

  // Controller state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/n_ms_c2_converter_chunk_negator.sv
// One chunk of a ripple invert-plus-carry negation; passes the operand through when not negating.
module n_chunk_negator #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  input  logic         cin_i,
  output logic [W-1:0] res_c,
  output logic         cout_c
);

  logic [W:0] sum_c;

  assign sum_c = {1'b0, ~a_i} + {{W{1'b0}}, cin_i};

  // Select negated chunk or pass-through; carry only propagates while negating
  always_comb begin
    res_c  = a_i;
    cout_c = cin_i;
    if (neg_i) begin
      res_c  = sum_c[W-1:0];
      cout_c = sum_c[W];
    end
  end

endmodule

// File: rtl/n_ms_c2_converter.sv
// Multi-cycle MS <-> C2 converter, CHUNK bits negated per clock, valid/ready on both sides.
// Optional feature: define N_MS_C2_CONVERTER_SAT_EN to saturate overflowing MS->C2 results.
import ms_c2_pkg::*;

module n_ms_c2_converter #(
  parameter int unsigned N     = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [N-1:0] x,
  input  logic         sgn_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] z,
  output logic         sgn_out,
  output logic         ow
);

  localparam int unsigned NCH   = N / CHUNK;
  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef N_MS_C2_CONVERTER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Reject unsupported geometries at elaboration
  generate
    if (N < 2 || CHUNK == 0 || (N % CHUNK) != 0) begin : g_bad_param
      $error("n_ms_c2_converter: N must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     x_q, x_d;
  logic             mode_q, mode_d;
  logic             sgn_q, sgn_d;
  logic             neg_q, neg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     z_q, z_d;
  logic             sgn_out_q, sgn_out_d;
  logic             ow_q, ow_d;

  logic [CHUNK-1:0] chunk_x;
  logic [CHUNK-1:0] chunk_res;
  logic             chunk_cout;
  logic [N-1:0]     acc_merged;
  logic             ow_fin;
  logic [N-1:0]     z_fin;
  logic             sgn_fin;

  // Chunk multiplexer feeding the single negator
  always_comb begin
    chunk_x = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (idx_q == IDX_W'(c)) chunk_x = x_q[c*CHUNK +: CHUNK];
    end
  end

  n_chunk_negator #(
    .W(CHUNK)
  ) u_negator (
    .a_i    (chunk_x),
    .neg_i  (neg_q),
    .cin_i  (carry_q),
    .res_c  (chunk_res),
    .cout_c (chunk_cout)
  );

  // Drop the processed chunk into its slot of the partial result
  always_comb begin
    acc_merged = acc_q;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (idx_q == IDX_W'(c)) acc_merged[c*CHUNK +: CHUNK] = chunk_res;
    end
  end

  // Final result flags; the last carry-out is discarded so negative zero maps to zero
  always_comb begin
    ow_fin  = (mode_q == MODE_MS2C2) & x_q[N-1] & ~(sgn_q & ~(|x_q[N-2:0]));
    z_fin   = acc_merged;
    if (SAT_EN && ow_fin) begin
      z_fin = sgn_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
    sgn_fin = (mode_q == MODE_MS2C2) ? z_fin[N-1] : x_q[N-1];
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    mode_d      = mode_q;
    sgn_d       = sgn_q;
    neg_d       = neg_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    z_d         = z_q;
    sgn_out_d   = sgn_out_q;
    ow_d        = ow_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d        = x;
          mode_d     = mode;
          sgn_d      = sgn_in;
          neg_d      = (mode == MODE_C22MS) ? x[N-1] : sgn_in;
          idx_d      = '0;
          carry_d    = 1'b1;
          acc_d      = '0;
          state_d    = ST_BUSY;
          in_ready_d = 1'b0;
        end
      end
      ST_BUSY: begin
        acc_d   = acc_merged;
        carry_d = chunk_cout;
        if (idx_q == IDX_W'(NCH - 1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          z_d         = z_fin;
          sgn_out_d   = sgn_fin;
          ow_d        = ow_fin;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      mode_q      <= MODE_MS2C2;
      sgn_q       <= 1'b0;
      neg_q       <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      z_q         <= '0;
      sgn_out_q   <= 1'b0;
      ow_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      mode_q      <= mode_d;
      sgn_q       <= sgn_d;
      neg_q       <= neg_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      sgn_out_q   <= sgn_out_d;
      ow_q        <= ow_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign sgn_out   = sgn_out_q;
  assign ow        = ow_q;

endmodule
